uart_port: RTL and testbench
============================

UART_PORT -- requirements
Module: uart_port

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: reset value of the baud divisor, in clocks per serial bit.
REQ-002 The block SHALL have parameter TX_DEPTH, default 4: TX FIFO depth in entries (power of 2).
REQ-003 Port: clk  input  1  single design clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: Address  input  32  address from Memory_Map_Decoder; only Address[3:2] is decoded.
REQ-006 Port: DataIn  input  32  write data from the decoder.
REQ-007 Port: DataOut  output  32  read data to the decoder.
REQ-008 Port: Select  input  1  chip select from the decoder.
REQ-009 Port: MemWrite  input  1  write strobe from the Control Unit.
REQ-010 Port: MemRead  input  1  read strobe from the Control Unit.
REQ-011 Port: uart_rx  input  1  serial input, asynchronous to clk, idle high.
REQ-012 Port: uart_tx  output  1  serial output, idle high.

Function
REQ-013 A write SHALL occur on a rising clk edge with Select=1 and MemWrite=1; a read-side-effect edge SHALL have Select=1 and MemRead=1.
REQ-014 DataOut SHALL be combinational from Address[3:2] and state, and 0 when Select=0.
REQ-015 Register map: 0 TXDATA (W), 1 RXDATA (R), 2 STATUS (R/W1C), 3 DIVISOR (R/W).
REQ-016 TXDATA write, FIFO not full: push DataIn[7:0]; FIFO full: write dropped, STATUS.tx_ovf set; reads return 0.
REQ-017 Fullness SHALL be evaluated before any same-cycle pop: a write to a full FIFO is dropped even if the TX FSM pops that cycle.
REQ-018 RXDATA read SHALL return {24'b0, rx_byte}; the read-side-effect edge SHALL clear rx_valid.
REQ-019 STATUS bits: [0] tx_full, [1] tx_empty, [2] tx_busy, [3] rx_valid, [4] rx_overrun, [5] tx_ovf, [6] rx_frame_err; [31:7]=0.
REQ-020 A STATUS write with DataIn[n]=1 SHALL clear sticky bit n (n=4,5,6); other bits are unaffected.
REQ-021 DIVISOR SHALL be 16 bits, read zero-extended; writing 0 SHALL store 1; a change takes effect at the next frame start, never mid-frame.
REQ-022 TX FSM states: IDLE, START, DATA, STOP; frame 8N1, LSB first, each bit exactly DIVISOR clocks.
REQ-023 IDLE->START on the first edge with the FIFO non-empty; that edge SHALL pop the FIFO head and latch the divisor.
REQ-024 START->DATA after 1 bit, DATA->STOP after 8 bits, STOP->IDLE after 1 bit; tx_busy=1 in every state except IDLE.
REQ-025 uart_tx SHALL be driven from a register: 0 in START, the data bit in DATA, 1 in STOP and IDLE.
REQ-026 RX SHALL pass uart_rx through a 2-flop synchronizer; RX FSM states: IDLE, START, DATA, STOP.
REQ-027 IDLE->START on a synchronized falling edge; START SHALL resample at DIVISOR/2 (floor, minimum 1) clocks and return to IDLE if high (glitch).
REQ-028 DATA SHALL sample 8 bits at DIVISOR-clock spacing from the start-bit midpoint, LSB first.
REQ-029 STOP sample high: load rx_byte, set rx_valid; if rx_valid was already 1, set rx_overrun and overwrite.
REQ-030 STOP sample low: set rx_frame_err, discard the byte, leave rx_valid unchanged, return to IDLE.
REQ-031 If an RXDATA read clears rx_valid on the same edge that a new byte loads, the load SHALL win: rx_valid=1, no overrun.
REQ-032 FIFO pointers SHALL wrap modulo TX_DEPTH, with one extra bit to distinguish full from empty.

Reset
REQ-033 Asserting rst SHALL immediately set: both FSMs to IDLE, FIFO empty, uart_tx=1, rx_byte=0, all STATUS flags 0 except tx_empty=1, DIVISOR=CLKS_PER_BIT, synchronizer flops=1.
REQ-034 Reset mid-frame SHALL abort both frames, discard FIFO contents, and drive uart_tx high asynchronously.

Verification
REQ-035 DIVISOR=4; write TXDATA=0xA5 -> uart_tx low for 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high; tx_busy=1 for exactly 40 clocks.
REQ-036 Five back-to-back TXDATA writes 0x01..0x05 with TX_DEPTH=4, FSM idle -> first write pops at once, fifth accepted only if space; otherwise tx_ovf=1 and bytes transmit in order with no gap beyond IDLE->START.
REQ-037 Loop uart_tx to uart_rx, DIVISOR=8, send 0x3C -> rx_valid=1 with RXDATA=0x0000003C; after the RXDATA read, rx_valid=0.
REQ-038 Drive two RX frames 0x11 then 0x22 without reading -> RXDATA=0x22, rx_overrun=1; a STATUS write of 0x10 clears only rx_overrun.
REQ-039 RX frame with stop bit low -> rx_frame_err=1 and rx_valid unchanged; a 1-clock low glitch on idle uart_rx produces no flags.
REQ-040 Assert rst during DATA of a TX frame -> uart_tx=1 with no clock edge; STATUS=0x00000002 and DIVISOR=CLKS_PER_BIT after release.

Source files
------------

// File: rtl/uart_port.sv
`default_nettype none
// ============================================================================
// Module   : uart_port
// Purpose  : Memory-mapped 8N1 UART with a small TX FIFO, a programmable
//            baud divisor and sticky error flags.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1   design clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   Address   in  32   bus address, only [3:2] decoded
//   DataIn    in  32   bus write data
//   DataOut   out 32   bus read data (combinational, 0 when not selected)
//   Select    in   1   chip select
//   MemWrite  in   1   write strobe
//   MemRead   in   1   read strobe (RXDATA read clears rx_valid)
//   uart_rx   in   1   serial input, asynchronous, idle high
//   uart_tx   out  1   serial output, registered, idle high
// Register map (Address[3:2]): 0 TXDATA, 1 RXDATA, 2 STATUS, 3 DIVISOR
// ============================================================================
module uart_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    input  logic        Select,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int          AW        = $clog2(TX_DEPTH);
    localparam logic [15:0] C_DIV_RST = 16'(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

    // ---------------- bus decode ----------------
    logic [1:0] w_sel;
    logic       w_wr_txdata, w_wr_status, w_wr_div, w_rd_rxdata;
    logic       w_unused_bits;

    assign w_sel       = Address[3:2];
    assign w_wr_txdata = Select & MemWrite & (w_sel == 2'd0);
    assign w_wr_status = Select & MemWrite & (w_sel == 2'd2);
    assign w_wr_div    = Select & MemWrite & (w_sel == 2'd3);
    assign w_rd_rxdata = Select & MemRead  & (w_sel == 2'd1);
    assign w_unused_bits = ^{Address[31:4], Address[1:0], DataIn[31:16]};

    // ---------------- divisor ----------------
    logic [15:0] r_divisor;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_divisor <= C_DIV_RST;
        else if (w_wr_div)
            r_divisor <= (DataIn[15:0] == 16'd0) ? 16'd1 : DataIn[15:0];
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]  r_fifo [TX_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic        w_full, w_empty, w_push, w_pop;
    state_t      r_tx_state, w_tx_next;

    // Extra MSB distinguishes full (MSBs differ) from empty (pointers equal).
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // Fullness is judged on the pre-edge pointers, so a same-edge pop never admits a write.
    assign w_push  = w_wr_txdata & ~w_full;
    assign w_pop   = (r_tx_state == S_IDLE) & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr[AW-1:0]] <= DataIn[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    logic [15:0] r_tx_cnt, r_tx_div;
    logic [2:0]  r_tx_bits;
    logic [7:0]  r_tx_shift;
    logic        w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_cnt == r_tx_div - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tx_state <= S_IDLE;
        else     r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            S_IDLE:  if (!w_empty)                            w_tx_next = S_START;
            S_START: if (w_tx_bit_end)                        w_tx_next = S_DATA;
            S_DATA:  if (w_tx_bit_end && r_tx_bits == 3'd7)   w_tx_next = S_STOP;
            S_STOP:  if (w_tx_bit_end)                        w_tx_next = S_IDLE;
            default:                                          w_tx_next = S_IDLE;
        endcase
    end

    // uart_tx is registered one step ahead: it changes on the same edge the state does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_cnt   <= '0;
            r_tx_div   <= C_DIV_RST;
            r_tx_bits  <= '0;
            r_tx_shift <= '0;
            uart_tx    <= 1'b1;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    r_tx_cnt <= '0;
                    if (!w_empty) begin
                        r_tx_shift <= r_fifo[r_rd_ptr[AW-1:0]];
                        r_tx_div   <= r_divisor;
                        uart_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt  <= '0;
                        r_tx_bits <= '0;
                        uart_tx   <= r_tx_shift[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_bits  <= r_tx_bits + 3'd1;
                        r_tx_shift <= r_tx_shift >> 1;
                        uart_tx    <= (r_tx_bits == 3'd7) ? 1'b1 : r_tx_shift[1];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                default: begin
                    r_tx_cnt <= w_tx_bit_end ? 16'd0 : r_tx_cnt + 16'd1;
                end
            endcase
        end
    end

    // ---------------- RX ----------------
    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    state_t      r_rx_state, w_rx_next;
    logic [15:0] r_rx_cnt, r_rx_div, w_rx_half;
    logic [2:0]  r_rx_bits;
    logic [7:0]  r_rx_shift, r_rx_byte;
    logic        w_rx_fall, w_rx_mid, w_rx_bit_end, w_rx_load, w_rx_ferr;

    assign w_rx_fall    = r_rx_prev & ~r_rx_sync;
    assign w_rx_half    = (r_rx_div[15:1] == 15'd0) ? 16'd1 : {1'b0, r_rx_div[15:1]};
    assign w_rx_mid     = (r_rx_cnt == w_rx_half - 16'd1);
    assign w_rx_bit_end = (r_rx_cnt == r_rx_div - 16'd1);
    assign w_rx_load    = (r_rx_state == S_STOP) & w_rx_bit_end &  r_rx_sync;
    assign w_rx_ferr    = (r_rx_state == S_STOP) & w_rx_bit_end & ~r_rx_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= S_IDLE;
        end else begin
            r_rx_meta  <= uart_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            S_IDLE:  if (w_rx_fall)                          w_rx_next = S_START;
            // A start bit that is high again at its midpoint was a glitch.
            S_START: if (w_rx_mid)                           w_rx_next = r_rx_sync ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_bit_end && r_rx_bits == 3'd7)  w_rx_next = S_STOP;
            S_STOP:  if (w_rx_bit_end)                       w_rx_next = S_IDLE;
            default:                                         w_rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_cnt   <= '0;
            r_rx_div   <= C_DIV_RST;
            r_rx_bits  <= '0;
            r_rx_shift <= '0;
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    r_rx_cnt <= '0;
                    if (w_rx_fall) r_rx_div <= r_divisor;
                end
                S_START: begin
                    if (w_rx_mid) begin
                        r_rx_cnt  <= '0;
                        r_rx_bits <= '0;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_bits  <= r_rx_bits + 3'd1;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: begin
                    r_rx_cnt <= w_rx_bit_end ? 16'd0 : r_rx_cnt + 16'd1;
                end
            endcase
        end
    end

    // ---------------- status flags ----------------
    logic r_rx_valid, r_rx_ovr, r_tx_ovf, r_rx_ferr;

    // Sets are written after clears so a same-edge set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            if (w_wr_status && DataIn[4]) r_rx_ovr  <= 1'b0;
            if (w_wr_status && DataIn[5]) r_tx_ovf  <= 1'b0;
            if (w_wr_status && DataIn[6]) r_rx_ferr <= 1'b0;
            if (w_rd_rxdata)              r_rx_valid <= 1'b0;
            if (w_rx_load) begin
                r_rx_byte  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                // A byte read out on this very edge is not lost, so no overrun.
                if (r_rx_valid && !w_rd_rxdata) r_rx_ovr <= 1'b1;
            end
            if (w_rx_ferr)                r_rx_ferr <= 1'b1;
            if (w_wr_txdata && w_full)    r_tx_ovf  <= 1'b1;
        end
    end

    logic [31:0] w_status;
    assign w_status = {25'd0, r_rx_ferr, r_tx_ovf, r_rx_ovr, r_rx_valid,
                       (r_tx_state != S_IDLE), w_empty, w_full};

    always_comb begin
        DataOut = 32'd0;
        if (Select) begin
            case (w_sel)
                2'd1:    DataOut = {24'd0, r_rx_byte};
                2'd2:    DataOut = w_status;
                2'd3:    DataOut = {16'd0, r_divisor};
                default: DataOut = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_port
// Purpose  : Directed self-checking bench for uart_port: reset state,
//            divisor write, TX waveform, FIFO burst/overflow, loopback RX,
//            overrun, framing error, glitch rejection, mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Address, DataIn, DataOut;
    logic        Select, MemWrite, MemRead;
    logic        uart_tx, rx_line, rx_drv, loop_en;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rx_line = loop_en ? uart_tx : rx_drv;

    uart_port #(.CLKS_PER_BIT(16), .TX_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .Address(Address), .DataIn(DataIn), .DataOut(DataOut),
        .Select(Select), .MemWrite(MemWrite), .MemRead(MemRead),
        .uart_rx(rx_line), .uart_tx(uart_tx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] idx, input logic [31:0] data);
        @(negedge clk);
        Address = {28'd0, idx, 2'b00}; DataIn = data; Select = 1'b1; MemWrite = 1'b1;
        @(negedge clk);
        Select = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] idx, output logic [31:0] data);
        @(negedge clk);
        Address = {28'd0, idx, 2'b00}; Select = 1'b1; MemRead = 1'b1;
        #1 data = DataOut;
        @(negedge clk);
        Select = 1'b0; MemRead = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame on rx_drv, then hold idle for two bit times.
    task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int div);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = fr[i];
            repeat (div) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (2 * div) @(negedge clk);
    endtask

    // Decode one frame from uart_tx at 4 clocks per bit, sampling mid-bit.
    task automatic tx_decode(output logic [7:0] b, output int start_cyc, output logic ok);
        int n;
        n  = 0;
        ok = 1'b1;
        b  = '0;
        while (n < 300) begin
            @(negedge clk);
            if (uart_tx === 1'b0) break;
            n++;
        end
        if (n >= 300) ok = 1'b0;
        start_cyc = cyc;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (4) @(negedge clk);
        if (uart_tx !== 1'b1) ok = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [39:0] wave, busy, exp_wave;
        logic [9:0]  frame;
        logic [7:0]  bytes [5];
        int          starts [5];
        logic        oks [5];
        logic        found, seen_low;

        rst = 1'b1; Select = 0; MemWrite = 0; MemRead = 0;
        Address = '0; DataIn = '0; rx_drv = 1'b1; loop_en = 1'b0;
        idle(3);
        rst = 1'b0;

        // Reset state
        check("reset_uart_tx", 64'(uart_tx), 64'd1);
        bus_rd(2'd2, rd); check("reset_status", 64'(rd), 64'h2);
        bus_rd(2'd3, rd); check("reset_divisor", 64'(rd), 64'd16);
        bus_rd(2'd1, rd); check("reset_rxdata", 64'(rd), 64'd0);
        bus_rd(2'd0, rd); check("txdata_reads_zero", 64'(rd), 64'd0);

        // Divisor: 0 stores 1
        bus_wr(2'd3, 32'd0); bus_rd(2'd3, rd); check("divisor_zero_is_one", 64'(rd), 64'd1);
        bus_wr(2'd3, 32'd4); bus_rd(2'd3, rd); check("divisor_4", 64'(rd), 64'd4);

        // TX waveform for 0xA5 at 4 clocks/bit
        bus_wr(2'd0, 32'hA5);
        Select = 1'b1; Address = 32'h8;
        frame = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            wave[j]     = uart_tx;
            busy[j]     = DataOut[2];
            exp_wave[j] = frame[j / 4];
        end
        check("tx_a5_wave", 64'(wave), 64'(exp_wave));
        check("tx_a5_busy40", 64'(busy), 64'hFF_FFFF_FFFF);
        @(negedge clk);
        check("tx_a5_busy_end", 64'(DataOut[2]), 64'd0);
        check("tx_a5_idle_high", 64'(uart_tx), 64'd1);
        Select = 1'b0;

        // Six back-to-back writes: five fit (one popped at once), sixth dropped
        fork
            begin
                @(negedge clk);
                Select = 1'b1; MemWrite = 1'b1; Address = 32'h0;
                for (int k = 1; k <= 6; k++) begin
                    DataIn = k;
                    @(negedge clk);
                end
                MemWrite = 1'b0; Address = 32'h8;
                #1 check("burst_status_full_ovf", 64'(DataOut), 64'h25);
                Select = 1'b0;
            end
            begin
                for (int f = 0; f < 5; f++) tx_decode(bytes[f], starts[f], oks[f]);
            end
        join
        for (int f = 0; f < 5; f++) begin
            check($sformatf("burst_byte%0d", f), 64'(bytes[f]), 64'(f + 1));
            check($sformatf("burst_frame_ok%0d", f), 64'(oks[f]), 64'd1);
        end
        for (int f = 0; f < 4; f++)
            check($sformatf("burst_gap%0d", f), 64'(starts[f+1] - starts[f]), 64'd41);
        idle(5);
        bus_rd(2'd2, rd); check("burst_status_after", 64'(rd), 64'h22);
        bus_wr(2'd2, 32'h20);
        bus_rd(2'd2, rd); check("tx_ovf_cleared", 64'(rd), 64'h2);

        // Loopback at 8 clocks/bit
        loop_en = 1'b1;
        bus_wr(2'd3, 32'd8);
        bus_wr(2'd0, 32'h3C);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            bus_rd(2'd2, rd);
            if (rd[3]) found = 1'b1;
        end
        check("loop_rx_valid", 64'(found), 64'd1);
        bus_rd(2'd1, rd); check("loop_rxdata", 64'(rd), 64'h3C);
        idle(20);
        bus_rd(2'd2, rd); check("loop_valid_cleared", 64'(rd), 64'h2);
        loop_en = 1'b0;

        // Overrun: two frames without reading
        send_rx(8'h11, 1'b1, 8);
        send_rx(8'h22, 1'b1, 8);
        bus_rd(2'd2, rd); check("overrun_status", 64'(rd), 64'h1A);
        bus_wr(2'd2, 32'h10);
        bus_rd(2'd2, rd); check("overrun_w1c_only", 64'(rd), 64'h0A);
        bus_rd(2'd1, rd); check("overrun_rxdata", 64'(rd), 64'h22);
        bus_rd(2'd2, rd); check("overrun_read_clears", 64'(rd), 64'h2);

        // Framing error keeps the previous byte and rx_valid
        send_rx(8'h33, 1'b1, 8);
        send_rx(8'h55, 1'b0, 8);
        bus_rd(2'd2, rd); check("frame_err_status", 64'(rd), 64'h4A);
        bus_rd(2'd1, rd); check("frame_err_rxdata", 64'(rd), 64'h33);
        bus_wr(2'd2, 32'h40);
        bus_rd(2'd2, rd); check("frame_err_cleared", 64'(rd), 64'h2);

        // One-clock glitch on idle line
        @(negedge clk); rx_drv = 1'b0;
        @(negedge clk); rx_drv = 1'b1;
        idle(40);
        bus_rd(2'd2, rd); check("glitch_no_flags", 64'(rd), 64'h2);

        // Reset during DATA of a frame of zeros, with a second byte queued
        bus_wr(2'd3, 32'd4);
        bus_wr(2'd0, 32'h00);
        bus_wr(2'd0, 32'h00);
        idle(10);
        check("mid_frame_tx_low", 64'(uart_tx), 64'd0);
        #2 rst = 1'b1;
        #1 check("async_reset_tx_high", 64'(uart_tx), 64'd1);
        idle(2);
        rst = 1'b0;
        bus_rd(2'd2, rd); check("post_reset_status", 64'(rd), 64'h2);
        bus_rd(2'd3, rd); check("post_reset_divisor", 64'(rd), 64'd16);
        seen_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) seen_low = 1'b1;
        end
        check("fifo_discarded", 64'(seen_low), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
